// File: rtl/whack_pkg.sv
// Shared types and defaults for the whack game core.
package whack_pkg;

  // FSM state encoding; values are visible on the game_state output.
  typedef enum logic [2:0] {
    StLobby = 3'd0,
    StPick  = 3'd1,
    StArmed = 3'd2,
    StOver  = 3'd3
  } game_state_e;

  // Board clock rate: one game second is this many CLOCK_50 cycles.
  localparam int unsigned DefaultClkHz = 50_000_000;

endpackage

// File: rtl/strike_detect.sv
// Debounced strike detector. A nonzero box id that holds for DEBOUNCE cycles
// fires a single strike, then the detector stays disarmed until the sensor has
// read idle (0) for DEBOUNCE cycles, so one physical hit produces one strike.
module strike_detect #(
  parameter int unsigned BOX_W    = 3,
  parameter int unsigned DEBOUNCE = 1024
) (
  input  logic             CLOCK_50,
  input  logic             resetn,
  input  logic [BOX_W-1:0] box_address,
  output logic             strike,
  output logic [BOX_W-1:0] strike_box
);

  localparam int unsigned    CntW   = $clog2(DEBOUNCE + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE);

  logic [BOX_W-1:0] prev_q, prev_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             armed_q, armed_d;
  logic [CntW-1:0]  run_len;
  logic             stable;

  // Length of the current run of identical samples, including this cycle.
  always_comb begin
    run_len = CntW'(1);
    if (box_address != prev_q) begin
      run_len = CntW'(1);
    end else if (cnt_q == CntMax) begin
      run_len = CntMax;
    end else begin
      run_len = cnt_q + 1'b1;
    end
    stable = (run_len == CntMax);
  end

  // Strike fires on the DEBOUNCE-th stable cycle; arming needs a stable idle run.
  always_comb begin
    strike  = armed_q && stable && (box_address != '0);
    prev_d  = box_address;
    cnt_d   = run_len;
    armed_d = armed_q;
    if (strike) begin
      armed_d = 1'b0;
    end else if (stable && (box_address == '0)) begin
      armed_d = 1'b1;
    end
  end

  assign strike_box = box_address;

  // Detector state; comes out of reset disarmed.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      prev_q  <= '0;
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
  end

endmodule

// File: rtl/whack_game_core.sv
// Game-logic core: lobby -> pick/armed play loop -> game over. Draws targets
// from the LFSR, scores debounced strikes, runs the seconds countdown and the
// per-target timeout, and keeps a session high score.
module whack_game_core
  import whack_pkg::*;
#(
  parameter int unsigned N_BOXES       = 3,
  parameter int unsigned BOX_W         = 3,
  parameter int unsigned SCORE_W       = 11,
  parameter int unsigned CLK_HZ        = DefaultClkHz,
  parameter int unsigned GAME_SECS     = 60,
  parameter int unsigned TARGET_CYCLES = 75_000_000,
  parameter int unsigned DEBOUNCE      = 1024,
  parameter int unsigned MISS_PENALTY  = 1
) (
  input  logic               CLOCK_50,
  input  logic               resetn,
  input  logic               start,
  input  logic [BOX_W-1:0]   box_address,
  input  logic [BOX_W-1:0]   lfsr_value,
  output logic [BOX_W-1:0]   target,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] high_score,
  output logic [7:0]         seconds_left,
  output logic [2:0]         game_state,
  output logic               hit_pulse,
  output logic               miss_pulse,
  output logic               lobby_sound,
  output logic               game_over
);

  localparam int unsigned PresW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned TmrW  = (TARGET_CYCLES > 1) ? $clog2(TARGET_CYCLES) : 1;

  localparam logic [PresW-1:0]   PresLast = PresW'(CLK_HZ - 1);
  localparam logic [TmrW-1:0]    TmrLast  = TmrW'(TARGET_CYCLES - 1);
  localparam logic [SCORE_W-1:0] ScoreMax = {SCORE_W{1'b1}};
  localparam logic [SCORE_W-1:0] Penalty  = SCORE_W'(MISS_PENALTY);
  localparam logic [7:0]         SecsInit = 8'(GAME_SECS);
  localparam logic [BOX_W-1:0]   NBox     = BOX_W'(N_BOXES);

  game_state_e        state_q, state_d;
  logic [BOX_W-1:0]   target_q, target_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] high_q, high_d;
  logic [7:0]         secs_q, secs_d;
  logic [PresW-1:0]   pres_q, pres_d;
  logic [TmrW-1:0]    tmr_q, tmr_d;
  logic               hit_q, hit_d;
  logic               miss_q, miss_d;
  logic               start_q;

  logic               strike;
  logic [BOX_W-1:0]   strike_box;
  logic               start_rise;
  logic               lfsr_ok;
  logic [SCORE_W-1:0] score_inc;
  logic [SCORE_W-1:0] score_dec;

  strike_detect #(
    .BOX_W    (BOX_W),
    .DEBOUNCE (DEBOUNCE)
  ) u_strike_detect (
    .CLOCK_50    (CLOCK_50),
    .resetn      (resetn),
    .box_address (box_address),
    .strike      (strike),
    .strike_box  (strike_box)
  );

  // Start edge, target acceptance and saturating score arithmetic.
  always_comb begin
    start_rise = start && !start_q;
    // A single-box game can never pick a different box, so skip that rule.
    lfsr_ok    = (lfsr_value != '0) && (lfsr_value <= NBox) &&
                 ((N_BOXES == 1) || (lfsr_value != target_q));
    score_inc  = (score_q == ScoreMax) ? score_q : score_q + 1'b1;
    score_dec  = (score_q < Penalty) ? '0 : score_q - Penalty;
  end

  // Next-state for the FSM, timers and score.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    score_d  = score_q;
    high_d   = high_q;
    secs_d   = secs_q;
    pres_d   = pres_q;
    tmr_d    = tmr_q;
    hit_d    = 1'b0;
    miss_d   = 1'b0;

    unique case (state_q)
      StLobby, StOver: begin
        if (start_rise) begin
          score_d = '0;
          secs_d  = SecsInit;
          pres_d  = '0;
          state_d = StPick;
        end
      end
      StPick: begin
        if (lfsr_ok) begin
          target_d = lfsr_value;
          tmr_d    = '0;
          state_d  = StArmed;
        end
      end
      StArmed: begin
        tmr_d = tmr_q + 1'b1;
        // A strike outranks a timeout landing in the same cycle.
        if (strike) begin
          if (strike_box == target_q) begin
            score_d = score_inc;
            hit_d   = 1'b1;
          end else begin
            score_d = score_dec;
            miss_d  = 1'b1;
          end
          state_d = StPick;
        end else if (tmr_q == TmrLast) begin
          score_d = score_dec;
          miss_d  = 1'b1;
          state_d = StPick;
        end
      end
      default: state_d = StLobby;
    endcase

    // Countdown overrides the play transition; the final strike is already in score_d.
    if ((state_q == StPick) || (state_q == StArmed)) begin
      if (pres_q == PresLast) begin
        pres_d = '0;
        secs_d = secs_q - 8'd1;
        if (secs_q == 8'd1) begin
          state_d  = StOver;
          target_d = '0;
          if (score_d > high_q) begin
            high_d = score_d;
          end
        end
      end else begin
        pres_d = pres_q + 1'b1;
      end
    end
  end

  // All game state; reset aborts any game in progress and clears the high score.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StLobby;
      target_q <= '0;
      score_q  <= '0;
      high_q   <= '0;
      secs_q   <= SecsInit;
      pres_q   <= '0;
      tmr_q    <= '0;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      score_q  <= score_d;
      high_q   <= high_d;
      secs_q   <= secs_d;
      pres_q   <= pres_d;
      tmr_q    <= tmr_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
      start_q  <= start;
    end
  end

  assign target       = target_q;
  assign score        = score_q;
  assign high_score   = high_q;
  assign seconds_left = secs_q;
  assign game_state   = state_q;
  assign hit_pulse    = hit_q;
  assign miss_pulse   = miss_q;
  assign lobby_sound  = (state_q == StLobby);
  assign game_over    = (state_q == StOver);

endmodule
